simon_round_controller: RTL and testbench

SIMON_ROUND_CONTROLLER -- requirements
Module: simon_round_controller

---
 rtl/simon_round_controller_if.sv | 29 ++
 rtl/simon_round_controller.sv | 107 ++++++++++
 tb/tb_simon_round_controller.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_round_controller_if.sv
// Handshake and status bundle between the Simon round controller and its
// playback / keypad / display neighbours.
`timescale 1ns / 1ps
interface simon_round_controller_if #(
  parameter int unsigned MAX_LEN = 4
);
  logic                   start;
  logic [2*MAX_LEN-1:0]   seq_pattern;
  logic                   play_start;
  logic [2:0]             play_len;
  logic                   play_done;
  logic                   key_valid;
  logic [1:0]             key_dir;
  logic [2:0]             round;
  logic [2:0]             step_idx;
  logic                   busy;
  logic                   win;
  logic                   lose;

  modport master (
    input  start, seq_pattern, play_done, key_valid, key_dir,
    output play_start, play_len, round, step_idx, busy, win, lose
  );

  modport slave (
    output start, seq_pattern, play_done, key_valid, key_dir,
    input  play_start, play_len, round, step_idx, busy, win, lose
  );
endinterface

// File: rtl/simon_round_controller.sv
// Simon game round sequencer: grows the shown pattern one step per round and
// checks the player's key presses against it under a per-step timeout.
`timescale 1ns / 1ps
module simon_round_controller #(
  parameter int unsigned MAX_LEN = 4,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic                        clock,
  input  logic                        reset,
  simon_round_controller_if.master    bus
);

  localparam int unsigned TimerW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [2:0]        RoundMax  = 3'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StWaitPlay,
    StInput,
    StWin,
    StLose
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           round_q, round_d;
  logic [2:0]           step_q, step_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [2*MAX_LEN-1:0] seq_q, seq_d;
  logic [1:0]           exp_dir;

  assign exp_dir = seq_q[{step_q, 1'b0} +: 2];

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    step_d  = step_q;
    timer_d = timer_q;
    seq_d   = seq_q;
    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (bus.start) begin
          seq_d   = bus.seq_pattern;
          round_d = 3'd1;
          step_d  = '0;
          timer_d = '0;
          state_d = StPlay;
        end
      end
      StPlay: state_d = StWaitPlay;
      StWaitPlay: begin
        if (bus.play_done) begin
          step_d  = '0;
          timer_d = '0;
          state_d = StInput;
        end
      end
      StInput: begin
        // A key in the timeout cycle still counts; the timeout only fires without one.
        if (bus.key_valid) begin
          if (bus.key_dir != exp_dir) begin
            state_d = StLose;
          end else if (step_q < round_q - 3'd1) begin
            step_d  = step_q + 3'd1;
            timer_d = '0;
          end else if (round_q < RoundMax) begin
            round_d = round_q + 3'd1;
            state_d = StPlay;
          end else begin
            state_d = StWin;
          end
        end else if (timer_q == TimerLast) begin
          state_d = StLose;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      round_q <= '0;
      step_q  <= '0;
      timer_q <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.play_start = (state_q == StPlay);
  assign bus.play_len   = round_q;
  assign bus.round      = round_q;
  assign bus.step_idx   = step_q;
  assign bus.busy       = (state_q == StPlay) || (state_q == StWaitPlay) || (state_q == StInput);
  assign bus.win        = (state_q == StWin);
  assign bus.lose       = (state_q == StLose);

endmodule

// File: tb/tb_simon_round_controller.sv
// Bench for simon_round_controller: vector table, directed corner sequences
// and a randomized run against a game-level reference model.
`timescale 1ns / 1ps
module tb_simon_round_controller;
  localparam int unsigned MaxLen  = 4;
  localparam int unsigned Timeout = 8;

  localparam int PhOff     = 0;
  localparam int PhShow    = 1;
  localparam int PhShowing = 2;
  localparam int PhGuess   = 3;
  localparam int PhWon     = 4;
  localparam int PhLost    = 5;

  logic clock = 1'b0;
  logic reset;

  simon_round_controller_if #(.MAX_LEN(MaxLen)) bus ();

  simon_round_controller #(
    .MAX_LEN(MaxLen),
    .TIMEOUT(Timeout)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic       pd;
    logic       kv;
    logic [1:0] kd;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs [13];

  // Game-level reference model
  int m_phase, m_round, m_idx, m_wait, m_pat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [12:0] outs();
    return {bus.play_start, bus.play_len, bus.round, bus.step_idx, bus.busy, bus.win, bus.lose};
  endfunction

  function automatic logic [12:0] o(input int ps, input int pl, input int rnd, input int stp,
                                    input int bsy, input int w, input int l);
    return {ps[0], pl[2:0], rnd[2:0], stp[2:0], bsy[0], w[0], l[0]};
  endfunction

  task automatic idle_inputs();
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.play_done = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_dir   = 2'b00;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic begin_game(input logic [7:0] pat);
    bus.seq_pattern = pat;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic to_input();
    cyc();
    bus.play_done = 1'b1;
    cyc();
    bus.play_done = 1'b0;
  endtask

  task automatic keys(input int n, input logic [7:0] pat);
    for (int i = 0; i < n; i++) begin
      bus.key_valid = 1'b1;
      bus.key_dir   = pat[2*i +: 2];
      cyc();
      bus.key_valid = 1'b0;
    end
  endtask

  task automatic model_edge(input logic rst, input logic st, input logic [7:0] pat,
                            input logic pd, input logic kv, input logic [1:0] kd);
    if (rst) begin
      m_phase = PhOff; m_round = 0; m_idx = 0; m_wait = 0; m_pat = 0;
    end else if (m_phase == PhOff || m_phase == PhWon || m_phase == PhLost) begin
      if (st) begin
        m_pat = int'(pat); m_round = 1; m_idx = 0; m_wait = 0; m_phase = PhShow;
      end
    end else if (m_phase == PhShow) begin
      m_phase = PhShowing;
    end else if (m_phase == PhShowing) begin
      if (pd) begin
        m_phase = PhGuess; m_idx = 0; m_wait = 0;
      end
    end else begin
      if (kv) begin
        if (int'(kd) != ((m_pat >> (2 * m_idx)) & 3)) m_phase = PhLost;
        else if (m_idx + 1 < m_round) begin
          m_idx++; m_wait = 0;
        end else if (m_round < MaxLen) begin
          m_round++; m_phase = PhShow;
        end else m_phase = PhWon;
      end else if (m_wait + 1 >= Timeout) m_phase = PhLost;
      else m_wait++;
    end
  endtask

  function automatic logic [12:0] model_outs();
    int bsy;
    bsy = (m_phase == PhShow || m_phase == PhShowing || m_phase == PhGuess) ? 1 : 0;
    return o((m_phase == PhShow) ? 1 : 0, m_round, m_round, m_idx, bsy,
             (m_phase == PhWon) ? 1 : 0, (m_phase == PhLost) ? 1 : 0);
  endfunction

  initial begin
    int kv_per;
    logic [1:0] kd;

    // rst st pd kv kd : expected {ps, len, round, step, busy, win, lose}
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, o(1, 1, 1, 0, 1, 0, 0)};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, o(0, 1, 1, 0, 1, 0, 0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, o(0, 1, 1, 0, 1, 0, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, o(0, 1, 1, 0, 1, 0, 0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, o(1, 2, 2, 0, 1, 0, 0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, o(0, 2, 2, 0, 1, 0, 0)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, o(0, 2, 2, 0, 1, 0, 0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, o(0, 2, 2, 1, 1, 0, 0)};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, o(0, 2, 2, 1, 1, 0, 0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, o(0, 2, 2, 1, 0, 0, 1)};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, o(0, 2, 2, 1, 0, 0, 1)};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, o(0, 2, 2, 1, 0, 0, 1)};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, o(0, 0, 0, 0, 0, 0, 0)};

    bus.seq_pattern = 8'hE4;
    reset_dut();
    check("reset_outputs", 32'(outs()), 32'(o(0, 0, 0, 0, 0, 0, 0)));

    for (int i = 0; i < 13; i++) begin
      reset         = vecs[i].rst;
      bus.start     = vecs[i].st;
      bus.play_done = vecs[i].pd;
      bus.key_valid = vecs[i].kv;
      bus.key_dir   = vecs[i].kd;
      cyc();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    idle_inputs();

    // Full win through all four rounds
    reset_dut();
    begin_game(8'hE4);
    for (int r = 1; r <= 4; r++) begin
      check($sformatf("win_play_start_r%0d", r), 32'(bus.play_start), 32'd1);
      check($sformatf("win_play_len_r%0d", r), 32'(bus.play_len), 32'(r));
      to_input();
      keys(r, 8'hE4);
    end
    check("win_flag", 32'(bus.win), 32'd1);
    check("win_busy", 32'(bus.busy), 32'd0);
    check("win_round", 32'(bus.round), 32'd4);
    cyc();
    check("win_hold", 32'(outs()), 32'(o(0, 4, 4, 3, 0, 1, 0)));

    // Timeout on the first step
    reset_dut();
    begin_game(8'hE4);
    to_input();
    repeat (7) cyc();
    check("timeout_not_yet", 32'(bus.lose), 32'd0);
    cyc();
    check("timeout_lose", 32'(outs()), 32'(o(0, 1, 1, 0, 0, 0, 1)));

    // Key in the last allowed cycle advances, then timer restarts
    reset_dut();
    begin_game(8'hE4);
    to_input();
    keys(1, 8'hE4);
    to_input();
    repeat (7) cyc();
    keys(1, 8'hE4);
    check("late_key_step", 32'(outs()), 32'(o(0, 2, 2, 1, 1, 0, 0)));
    repeat (7) cyc();
    check("late_key_timer_restart", 32'(bus.lose), 32'd0);
    cyc();
    check("late_key_timeout", 32'(outs()), 32'(o(0, 2, 2, 1, 0, 0, 1)));

    // Restart from LOSE with a new pattern; later pattern changes are ignored
    begin_game(8'h1B);
    check("restart", 32'(outs()), 32'(o(1, 1, 1, 0, 1, 0, 0)));
    bus.seq_pattern = 8'hE4;
    to_input();
    keys(1, 8'h1B);
    check("restart_new_pattern_r2", 32'(outs()), 32'(o(1, 2, 2, 0, 1, 0, 0)));
    to_input();
    keys(2, 8'h1B);
    check("restart_new_pattern_r3", 32'(outs()), 32'(o(1, 3, 3, 1, 1, 0, 0)));

    // Reset in the middle of round 3 input
    reset_dut();
    begin_game(8'hE4);
    to_input();
    keys(1, 8'hE4);
    to_input();
    keys(2, 8'hE4);
    to_input();
    keys(1, 8'hE4);
    check("mid_r3_state", 32'(outs()), 32'(o(0, 3, 3, 1, 1, 0, 0)));
    reset = 1'b1;
    bus.start = 1'b1;
    cyc();
    reset = 1'b0;
    bus.start = 1'b0;
    check("mid_reset", 32'(outs()), 32'(o(0, 0, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 3; i++) begin
      bus.play_done = 1'b1;
      bus.key_valid = 1'b1;
      cyc();
      check($sformatf("post_reset_quiet%0d", i), 32'(outs()), 32'(o(0, 0, 0, 0, 0, 0, 0)));
    end
    idle_inputs();
    begin_game(8'hE4);
    check("post_reset_start", 32'(outs()), 32'(o(1, 1, 1, 0, 1, 0, 0)));

    // Randomized run against the reference model
    kv_per = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) kv_per = ($urandom_range(1) == 1) ? 2 : 12;
      reset           = (c == 0) || ($urandom_range(199) == 0);
      bus.start       = ($urandom_range(15) == 0);
      bus.seq_pattern = 8'($urandom);
      bus.play_done   = ($urandom_range(3) == 0);
      bus.key_valid   = ($urandom_range(kv_per - 1) == 0);
      kd = 2'((m_pat >> (2 * m_idx)) & 3);
      bus.key_dir     = ($urandom_range(3) != 0) ? kd : 2'($urandom_range(3));
      model_edge(reset, bus.start, bus.seq_pattern, bus.play_done, bus.key_valid, bus.key_dir);
      cyc();
      check($sformatf("random_c%0d", c), 32'(outs()), 32'(model_outs()));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
